// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IF/MEM external bus arbiter.
// Holds the pipeline-wide constants that the arbiter reuses.
package mem_bus_arbiter_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam int   RegBus       = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_t;

    // Watchdog counter width: enough to hold the limit, clamped to 8..16 bits.
    function automatic int wd_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus watchdog: counts cycles spent in a bus transaction, flags expiry at the limit.
// Latency: expiry is combinational from the count; backpressure: none, clear/busy only.
`ifdef BUS_TIMEOUT_EN
module bus_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_busy,
    output logic o_expired
);

    localparam int CNT_W = wd_cnt_w(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_clr || !i_busy) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count is zero in the first busy cycle, so the limit-th busy cycle sees LIMIT-1.
    assign o_expired = i_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between IF and MEM (MEM priority), registered req/ack.
// Latency 2 cycles with a zero-wait slave; requesters are held off via stallreq_*_o.
// Optional bus timeout watchdog under BUS_TIMEOUT_EN (bus_err_o tied low otherwise).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = RegBus,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                stallreq_if_o,
    output logic                stallreq_mem_o,
    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                bus_err_o
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_t          r_state;
    logic                r_bus_cyc;
    logic                r_bus_stb;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [SEL_W-1:0]    r_bus_sel;
    logic                r_if_ack;
    logic                r_mem_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;

    logic                w_if_req;
    logic                w_mem_req;
    logic                w_timeout;
    logic                w_done;
    logic [DATA_W-1:0]   w_rdata;

    // A source's own ack cycle masks its still-held request so it is not re-issued.
    assign w_if_req  = if_req_i  & ~r_if_ack;
    assign w_mem_req = mem_req_i & ~r_mem_ack;

`ifdef BUS_TIMEOUT_EN
    logic w_busy;
    logic w_grant;
    logic w_expired;
    logic r_bus_err;

    assign w_busy    = (r_state != ARB_IDLE);
    assign w_grant   = (r_state == ARB_IDLE) && (w_mem_req || w_if_req);
    assign w_timeout = w_expired & ~bus_ack_i;
    assign bus_err_o = r_bus_err;

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_grant),
        .i_busy    (w_busy),
        .o_expired (w_expired)
    );
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    assign w_done  = bus_ack_i | w_timeout;
    assign w_rdata = (bus_ack_i && r_bus_we == WriteDisable) ? bus_rdata_i : DATA_W'(ZeroWord);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state     <= ARB_IDLE;
            r_bus_cyc   <= 1'b0;
            r_bus_stb   <= 1'b0;
            r_bus_we    <= WriteDisable;
            r_bus_addr  <= '0;
            r_bus_wdata <= DATA_W'(ZeroWord);
            r_bus_sel   <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= DATA_W'(ZeroWord);
            r_mem_rdata <= DATA_W'(ZeroWord);
`ifdef BUS_TIMEOUT_EN
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_mem_req) begin
                        r_state     <= ARB_BUSY_MEM;
                        r_bus_cyc   <= 1'b1;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= mem_we_i;
                        r_bus_addr  <= mem_addr_i;
                        r_bus_wdata <= mem_wdata_i;
                        r_bus_sel   <= mem_sel_i;
                    end else if (w_if_req) begin
                        r_state     <= ARB_BUSY_IF;
                        r_bus_cyc   <= 1'b1;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= WriteDisable;
                        r_bus_addr  <= if_addr_i;
                        r_bus_wdata <= DATA_W'(ZeroWord);
                        r_bus_sel   <= '1;
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_MEM: begin
                    if (w_done) begin
                        r_state   <= ARB_IDLE;
                        r_bus_cyc <= 1'b0;
                        r_bus_stb <= 1'b0;
                        r_bus_we  <= WriteDisable;
`ifdef BUS_TIMEOUT_EN
                        r_bus_err <= w_timeout;
`endif
                        if (r_state == ARB_BUSY_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rdata;
                        end else begin
                            r_mem_ack   <= 1'b1;
                            r_mem_rdata <= w_rdata;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus_cyc_o      = r_bus_cyc;
    assign bus_stb_o      = r_bus_stb;
    assign bus_we_o       = r_bus_we;
    assign bus_addr_o     = r_bus_addr;
    assign bus_wdata_o    = r_bus_wdata;
    assign bus_sel_o      = r_bus_sel;
    assign if_ack_o       = r_if_ack;
    assign if_rdata_o     = r_if_rdata;
    assign mem_ack_o      = r_mem_ack;
    assign mem_rdata_o    = r_mem_rdata;
    assign stallreq_if_o  = if_req_i  & ~r_if_ack;
    assign stallreq_mem_o = mem_req_i & ~r_mem_ack;

endmodule
